instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Purpose  : three-phase (FETCH/DECODE/EXEC) instruction sequencer for a small accumulator CPU.
// Latency  : 3 cycles per instruction; opcode is at the decoder 2 cycles after its address is presented.
// Backpress: none; start is only sampled in IDLE/HALT and ignored while busy.
//
// Optional feature macro: CYCLE_COUNTER_EN (busy-cycle counter on cycle_count; tied to 0 otherwise).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        run request (IDLE/HALT only)
//   prog_addr    program memory address (the PC register)
//   prog_data    synchronous program memory data, valid one cycle after prog_addr
//   opcode       IR[15:11] to the instruction decoder
//   operand      IR[10:0] immediate / data address
//   instr_valid  high only in EXEC, qualifies decoder write enables
//   busy         high in FETCH, DECODE, EXEC
//   halted       high in HALT
//   cycle_count  busy cycles in the current run (saturating)

module instruction_fetch_unit #(
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [10:0] prog_addr,
  input  logic [15:0] prog_data,
  output logic [4:0]  opcode,
  output logic [10:0] operand,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted,
  output logic [15:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [4:0] OP_HLT = 5'b00000;

  state_t      state;
  state_t      state_nxt;
  logic [10:0] pc;
  logic [10:0] pc_nxt;
  logic [15:0] ir;
  logic [15:0] ir_nxt;
  logic        start_accept;

  // A start is only honoured when the unit is not running.
  assign start_accept = start && ((state == IDLE) || (state == HALT));

  // ---------------------------------------------------------------------------
  // State, PC and IR registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;

    case (state)
      IDLE, HALT: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = RESET_PC;
        end
      end

      // Address is already on prog_addr; memory returns data next cycle.
      FETCH: begin
        state_nxt = DECODE;
      end

      // Memory data for the fetched address is valid now.
      DECODE: begin
        ir_nxt    = prog_data;
        state_nxt = EXEC;
      end

      // HLT freezes the PC on the halting instruction; everything else
      // advances, wrapping naturally at the 11-bit boundary.
      EXEC: begin
        if (ir[15:11] == OP_HLT) begin
          state_nxt = HALT;
        end else begin
          pc_nxt    = pc + 11'd1;
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = IDLE;
        pc_nxt    = RESET_PC;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state / PC / IR only
  // ---------------------------------------------------------------------------
  assign prog_addr   = pc;
  assign opcode      = ir[15:11];
  assign operand     = ir[10:0];
  assign instr_valid = (state == EXEC);
  assign busy        = (state == FETCH) || (state == DECODE) || (state == EXEC);
  assign halted      = (state == HALT);

  // ---------------------------------------------------------------------------
  // Busy-cycle counter
  // ---------------------------------------------------------------------------
`ifdef CYCLE_COUNTER_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'h0000;
    end else if (start_accept) begin
      cnt <= 16'h0000;
    end else if (busy && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign cycle_count = cnt;
`else
  assign cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

`ifdef CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start2;

  logic [10:0] prog_addr,   prog_addr2;
  logic [15:0] prog_data,   prog_data2;
  logic [4:0]  opcode,      opcode2;
  logic [10:0] operand,     operand2;
  logic        instr_valid, instr_valid2;
  logic        busy,        busy2;
  logic        halted,      halted2;
  logic [15:0] cycle_count, cycle_count2;

  logic [15:0] rom  [0:2047];
  logic [15:0] rom2 [0:2047];

  int tests_run;
  int tests_failed;

  instruction_fetch_unit #(.RESET_PC(11'd0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .busy        (busy),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  instruction_fetch_unit #(.RESET_PC(11'd2047)) dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .prog_addr   (prog_addr2),
    .prog_data   (prog_data2),
    .opcode      (opcode2),
    .operand     (operand2),
    .instr_valid (instr_valid2),
    .busy        (busy2),
    .halted      (halted2),
    .cycle_count (cycle_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memories
  always @(posedge clk) begin
    prog_data  <= rom[prog_addr];
    prog_data2 <= rom2[prog_addr2];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (prog_addr !== 11'd0) begin tests_failed++; $display("FAIL reset_prog_addr got %h want %h", prog_addr, 11'd0); end
    tests_run++;
    if (prog_addr2 !== 11'd2047) begin tests_failed++; $display("FAIL reset_prog_addr_hi got %h want %h", prog_addr2, 11'd2047); end
    tests_run++;
    if ({opcode, operand} !== 16'h0000) begin tests_failed++; $display("FAIL reset_ir got %h want 0000", {opcode, operand}); end
    tests_run++;
    if ({instr_valid, busy, halted} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {instr_valid, busy, halted}); end
    tests_run++;
    if (cycle_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_count got %h want 0000", cycle_count); end
    step;
    rst_n = 1'b1;
    // Release of reset must not start anything.
    for (int i = 0; i < 4; i++) begin
      step;
      tests_run++;
      if ({instr_valid, busy, halted} !== 3'b000) begin tests_failed++; $display("FAIL reset_release_idle cyc %0d got %b want 000", i, {instr_valid, busy, halted}); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ldi_halt;
    rom[0] = 16'h1805;
    rom[1] = 16'h0000;
    start = 1'b1;
    step;               // edge 0 -> cycle 1 FETCH
    start = 1'b0;
    tests_run++;
    if ({busy, instr_valid, prog_addr} !== {1'b1, 1'b0, 11'd0}) begin tests_failed++; $display("FAIL ldi_c1_fetch got b=%b v=%b a=%h want b=1 v=0 a=000", busy, instr_valid, prog_addr); end
    step;               // cycle 2 DECODE
    tests_run++;
    if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL ldi_c2_valid got %b want 0", instr_valid); end
    step;               // cycle 3 EXEC
    tests_run++;
    if ({instr_valid, opcode, operand} !== {1'b1, 5'b00011, 11'd5}) begin tests_failed++; $display("FAIL ldi_c3_exec got v=%b op=%b opr=%0d want v=1 op=00011 opr=5", instr_valid, opcode, operand); end
    step;               // cycle 4 FETCH pc=1, IR held
    tests_run++;
    if ({instr_valid, opcode, operand, prog_addr} !== {1'b0, 5'b00011, 11'd5, 11'd1}) begin tests_failed++; $display("FAIL ldi_c4_hold got v=%b op=%b opr=%0d a=%0d want v=0 op=00011 opr=5 a=1", instr_valid, opcode, operand, prog_addr); end
    step;               // cycle 5
    step;               // cycle 6 EXEC HLT
    tests_run++;
    if ({instr_valid, opcode} !== {1'b1, 5'b00000}) begin tests_failed++; $display("FAIL hlt_c6_exec got v=%b op=%b want v=1 op=00000", instr_valid, opcode); end
    step;               // cycle 7 HALT
    tests_run++;
    if ({halted, busy, instr_valid, prog_addr} !== {1'b1, 1'b0, 1'b0, 11'd1}) begin tests_failed++; $display("FAIL hlt_c7_state got h=%b b=%b v=%b a=%0d want h=1 b=0 v=0 a=1", halted, busy, instr_valid, prog_addr); end
    tests_run++;
    if (cycle_count !== (CNT_EN ? 16'd6 : 16'd0)) begin tests_failed++; $display("FAIL hlt_count got %0d want %0d", cycle_count, CNT_EN ? 6 : 0); end
    step;
    step;
    tests_run++;
    if ({halted, cycle_count} !== {1'b1, (CNT_EN ? 16'd6 : 16'd0)}) begin tests_failed++; $display("FAIL hlt_hold got h=%b cnt=%0d want h=1 cnt=%0d", halted, cycle_count, CNT_EN ? 6 : 0); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_restart_from_halt;
    bit seen;
    start = 1'b1;
    step;               // FETCH at RESET_PC
    start = 1'b0;
    tests_run++;
    if ({busy, halted, prog_addr} !== {1'b1, 1'b0, 11'd0}) begin tests_failed++; $display("FAIL restart_fetch got b=%b h=%b a=%0d want b=1 h=0 a=0", busy, halted, prog_addr); end
    tests_run++;
    if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL restart_count_clear got %0d want 0", cycle_count); end
    step;
    tests_run++;
    if (cycle_count !== (CNT_EN ? 16'd1 : 16'd0)) begin tests_failed++; $display("FAIL restart_count_1 got %0d want %0d", cycle_count, CNT_EN ? 1 : 0); end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step;
      if (halted) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL restart_halt_timeout got halted=%b want 1", halted); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back;
    logic [10:0] exp_opr;
    pulse_reset();
    rom[0] = 16'h1001;  // op 00010, opr 1
    rom[1] = 16'h2002;  // op 00100, opr 2
    rom[2] = 16'h3003;  // op 00110, opr 3
    rom[3] = 16'h0000;  // HLT
    start = 1'b1;       // held high for the whole run
    step;
    for (int c = 1; c <= 12; c++) begin
      tests_run++;
      if (instr_valid !== (c % 3 == 0)) begin tests_failed++; $display("FAIL b2b_valid cyc %0d got %b want %b", c, instr_valid, (c % 3 == 0)); end
      if (c % 3 == 1) begin
        tests_run++;
        if (prog_addr !== 11'((c - 1) / 3)) begin tests_failed++; $display("FAIL b2b_pc cyc %0d got %0d want %0d", c, prog_addr, (c - 1) / 3); end
      end
      if (c % 3 == 0) begin
        exp_opr = (c == 12) ? 11'd0 : 11'(c / 3);
        tests_run++;
        if (operand !== exp_opr) begin tests_failed++; $display("FAIL b2b_operand cyc %0d got %0d want %0d", c, operand, exp_opr); end
      end
      if (c == 3) begin
        tests_run++;
        if (opcode !== 5'b00010) begin tests_failed++; $display("FAIL b2b_opcode got %b want 00010", opcode); end
      end
      if (c == 12) start = 1'b0;
      step;
    end
    tests_run++;
    if ({halted, prog_addr} !== {1'b1, 11'd3}) begin tests_failed++; $display("FAIL b2b_halt got h=%b a=%0d want h=1 a=3", halted, prog_addr); end
    tests_run++;
    if (cycle_count !== (CNT_EN ? 16'd12 : 16'd0)) begin tests_failed++; $display("FAIL b2b_count got %0d want %0d", cycle_count, CNT_EN ? 12 : 0); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_pc_wrap;
    rom2[2047] = 16'h2001;  // ADD 1
    rom2[0]    = 16'h0000;  // HLT
    start2 = 1'b1;
    step;
    start2 = 1'b0;
    tests_run++;
    if (prog_addr2 !== 11'd2047) begin tests_failed++; $display("FAIL wrap_first_fetch got %0d want 2047", prog_addr2); end
    step;
    step;
    tests_run++;
    if ({instr_valid2, opcode2, operand2} !== {1'b1, 5'b00100, 11'd1}) begin tests_failed++; $display("FAIL wrap_exec got v=%b op=%b opr=%0d want v=1 op=00100 opr=1", instr_valid2, opcode2, operand2); end
    step;
    tests_run++;
    if ({busy2, instr_valid2, prog_addr2} !== {1'b1, 1'b0, 11'd0}) begin tests_failed++; $display("FAIL wrap_next_fetch got b=%b v=%b a=%0d want b=1 v=0 a=0", busy2, instr_valid2, prog_addr2); end
    step;
    step;
    step;
    tests_run++;
    if (halted2 !== 1'b1) begin tests_failed++; $display("FAIL wrap_halt got %b want 1", halted2); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_decode;
    pulse_reset();
    rom[0] = 16'h1805;
    rom[1] = 16'h2006;
    start = 1'b1;
    step;               // c1 FETCH
    start = 1'b0;
    step;               // c2
    step;               // c3 EXEC of 1805
    step;               // c4 FETCH pc=1
    step;               // c5 DECODE
    tests_run++;
    if ({opcode, prog_addr, busy} !== {5'b00011, 11'd1, 1'b1}) begin tests_failed++; $display("FAIL mid_pre got op=%b a=%0d b=%b want op=00011 a=1 b=1", opcode, prog_addr, busy); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({instr_valid, busy, halted} !== 3'b000) begin tests_failed++; $display("FAIL mid_rst_flags got %b want 000", {instr_valid, busy, halted}); end
    tests_run++;
    if ({opcode, operand, prog_addr} !== {5'd0, 11'd0, 11'd0}) begin tests_failed++; $display("FAIL mid_rst_regs got op=%b opr=%0d a=%0d want 0 0 0", opcode, operand, prog_addr); end
    tests_run++;
    if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL mid_rst_count got %0d want 0", cycle_count); end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step;
      tests_run++;
      if ({instr_valid, busy} !== 2'b00) begin tests_failed++; $display("FAIL mid_no_exec cyc %0d got v=%b b=%b want 0 0", i, instr_valid, busy); end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      rom[i]  = 16'h0000;
      rom2[i] = 16'h0000;
    end
    step;
    step;

    test_reset();
    test_ldi_halt();
    test_restart_from_halt();
    test_back_to_back();
    test_pc_wrap();
    test_reset_mid_decode();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
